// File: rtl/ascon_bdi_packer_pkg.sv
// Shared definitions for the ASCON bdi input formatter.
//   CCW         : core word width in bits (32 or 64)
//   CCB         : bytes per core word
//   data_type_e : type tag carried alongside every byte / word
package ascon_bdi_packer_pkg;

  localparam int unsigned CCW = 32;
  localparam int unsigned CCB = CCW / 8;

  typedef enum logic [3:0] {
    D_NULL  = 4'd0,
    D_NONCE = 4'd1,
    D_AD    = 4'd2,
    D_MSG   = 4'd3,
    D_TAG   = 4'd4,
    D_HASH  = 4'd5
  } data_type_e;

endpackage

// File: rtl/ascon_word_slot.sv
// Single-entry output register with valid/ready handshake.
//   clk, rst          : clock, synchronous active-high reset
//   i_load            : capture i_data/i_mask/i_type/i_eot/i_eoi (only when o_free)
//   i_ready           : downstream ready
//   o_free            : slot can take a word this cycle (empty or draining now)
//   o_data .. o_eoi   : held word; o_mask==0 means empty
module ascon_word_slot
  import ascon_bdi_packer_pkg::*;
#(
  parameter  int unsigned CCW = 32,
  localparam int unsigned NB  = CCW / 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [CCW-1:0] i_data,
  input  logic [NB-1:0]  i_mask,
  input  logic [3:0]     i_type,
  input  logic           i_eot,
  input  logic           i_eoi,
  input  logic           i_ready,
  output logic           o_free,
  output logic [CCW-1:0] o_data,
  output logic [NB-1:0]  o_mask,
  output logic [3:0]     o_type,
  output logic           o_eot,
  output logic           o_eoi
);

  logic [CCW-1:0] r_data;
  logic [NB-1:0]  r_mask;
  logic [3:0]     r_type;
  logic           r_eot;
  logic           r_eoi;

  assign o_free = (r_mask == '0) || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_mask <= '0;
      r_type <= D_NULL;
      r_eot  <= 1'b0;
      r_eoi  <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_mask <= i_mask;
      r_type <= i_type;
      r_eot  <= i_eot;
      r_eoi  <= i_eoi;
    end else if ((r_mask != '0) && i_ready) begin
      // drained with nothing to replace it: return to the idle values
      r_data <= '0;
      r_mask <= '0;
      r_type <= D_NULL;
      r_eot  <= 1'b0;
      r_eoi  <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_mask = r_mask;
  assign o_type = r_type;
  assign o_eot  = r_eot;
  assign o_eoi  = r_eoi;

endmodule

// File: rtl/ascon_bdi_packer.sv
// Byte-to-word formatter feeding ascon_core's bdi port.
//   clk, rst                         : clock, synchronous active-high reset
//   in_data/in_valid/in_ready        : byte stream with handshake
//   in_type/in_last/in_eoi           : byte type, end of segment, end of input
//   bdi/bdi_valid/bdi_ready          : packed word, byte-valid mask, core ready
//   bdi_type/bdi_eot/bdi_eoi         : word type, end of segment, end of input
// Partial words are only produced at the end of a segment. CCW must be 32 or 64.
module ascon_bdi_packer
  import ascon_bdi_packer_pkg::*;
#(
  parameter int unsigned CCW = ascon_bdi_packer_pkg::CCW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_type,
  input  logic               in_last,
  input  logic               in_eoi,
  output logic [CCW-1:0]     bdi,
  output logic [CCW/8-1:0]   bdi_valid,
  input  logic               bdi_ready,
  output logic [3:0]         bdi_type,
  output logic               bdi_eot,
  output logic               bdi_eoi
);

  localparam int unsigned NB = CCW / 8;
  localparam int unsigned CW = $clog2(NB);

  logic [CCW-1:0] r_data;
  logic [NB-1:0]  r_mask;
  logic [3:0]     r_type;
  logic           r_eot;
  logic           r_eoi;
  logic [CW-1:0]  r_cnt;
  logic           r_full;

  logic           w_accept;
  logic           w_complete;
  logic           w_free;
  logic           w_load;
  logic [CCW-1:0] w_nd;
  logic [NB-1:0]  w_nm;
  logic [CCW-1:0] w_ld_data;
  logic [NB-1:0]  w_ld_mask;
  logic [3:0]     w_ld_type;
  logic           w_ld_eot;
  logic           w_ld_eoi;

  assign in_ready   = !rst && !r_full;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && ((r_cnt == CW'(NB - 1)) || in_last);

  // pack register contents with the incoming byte merged in
  always_comb begin
    w_nd = r_data;
    w_nd[8*r_cnt +: 8] = in_data;
    w_nm = r_mask | (NB'(1) << r_cnt);
  end

  // a held full pack always goes first; otherwise a word completing now
  // bypasses the pack register straight into a free slot
  assign w_load    = (r_full || w_complete) && w_free;
  assign w_ld_data = r_full ? r_data : w_nd;
  assign w_ld_mask = r_full ? r_mask : w_nm;
  assign w_ld_type = r_full ? r_type : in_type;
  assign w_ld_eot  = r_full ? r_eot  : in_last;
  assign w_ld_eoi  = r_full ? r_eoi  : in_eoi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_mask <= '0;
      r_type <= D_NULL;
      r_eot  <= 1'b0;
      r_eoi  <= 1'b0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (r_full) begin
      if (w_free) begin
        r_data <= '0;
        r_mask <= '0;
        r_eot  <= 1'b0;
        r_eoi  <= 1'b0;
        r_full <= 1'b0;
      end
    end else if (w_complete) begin
      r_cnt <= '0;
      if (w_free) begin
        r_data <= '0;
        r_mask <= '0;
        r_eot  <= 1'b0;
        r_eoi  <= 1'b0;
      end else begin
        r_data <= w_nd;
        r_mask <= w_nm;
        r_type <= in_type;
        r_eot  <= in_last;
        r_eoi  <= in_eoi;
        r_full <= 1'b1;
      end
    end else if (w_accept) begin
      r_data <= w_nd;
      r_mask <= w_nm;
      r_type <= in_type;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  ascon_word_slot #(.CCW(CCW)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_ld_data),
    .i_mask  (w_ld_mask),
    .i_type  (w_ld_type),
    .i_eot   (w_ld_eot),
    .i_eoi   (w_ld_eoi),
    .i_ready (bdi_ready),
    .o_free  (w_free),
    .o_data  (bdi),
    .o_mask  (bdi_valid),
    .o_type  (bdi_type),
    .o_eot   (bdi_eot),
    .o_eoi   (bdi_eoi)
  );

endmodule
